// File: rtl/cpu_lockstep_cmp.sv
// Lockstep bus-transaction comparator: captures qualified bus cycles from the DUV and
// reference cores into per-side FIFOs, compares them in order and reports differences.

module cpu_lockstep_fifo #(
    parameter int DEPTH = 8,
    parameter int REC_W = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push_i,
    input  logic [REC_W-1:0]         rec_i,
    input  logic                     pop_i,
    output logic [REC_W-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full, accept;

    // A full FIFO still takes a record when its head leaves in the same cycle.
    assign full   = (level_q == FULL_LVL);
    assign accept = push_i & (~full | pop_i) & ~clr;
    assign drop_o = push_i & full & ~pop_i & ~clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (accept) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            case ({accept, pop_i})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wptr_q] <= rec_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign level_o = level_q;
endmodule

module cpu_lockstep_cmp #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int SKEW_LIMIT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       duv_syn_clk,
    input  logic [ADDR_W-1:0]          duv_addr_out,
    input  logic [DATA_W-1:0]          duv_data_out,
    input  logic [DATA_W-1:0]          duv_data_in,
    input  logic                       duv_ren,
    input  logic                       duv_wen,
    input  logic                       ref_syn_clk,
    input  logic [ADDR_W-1:0]          ref_addr_out,
    input  logic [DATA_W-1:0]          ref_data_out,
    input  logic [DATA_W-1:0]          ref_data_in,
    input  logic                       ref_ren,
    input  logic                       ref_wen,
    output logic                       mismatch,
    output logic                       err,
    output logic                       overflow,
    output logic                       timeout,
    output logic [ADDR_W+DATA_W:0]     first_duv_rec,
    output logic [ADDR_W+DATA_W:0]     first_ref_rec,
    output logic [31:0]                cmp_count,
    output logic [15:0]                err_count,
    output logic [$clog2(DEPTH):0]     duv_level,
    output logic [$clog2(DEPTH):0]     ref_level
);
    localparam int REC_W = 1 + ADDR_W + DATA_W;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int SW    = $clog2(SKEW_LIMIT + 1);
    localparam int DUV   = 0;
    localparam int REFS  = 1;
    localparam logic [SW-1:0] SKEW_MAX = SW'(SKEW_LIMIT);

    logic [1:0]                   syn, ren, wen, push, drop, nonempty;
    logic [1:0][ADDR_W-1:0]       addr;
    logic [1:0][DATA_W-1:0]       dout, din;
    logic [1:0][REC_W-1:0]        rec, head;
    logic [1:0][LW-1:0]           level;
    logic                         pop, differ;

    assign syn  = {ref_syn_clk, duv_syn_clk};
    assign ren  = {ref_ren, duv_ren};
    assign wen  = {ref_wen, duv_wen};
    assign addr = {ref_addr_out, duv_addr_out};
    assign dout = {ref_data_out, duv_data_out};
    assign din  = {ref_data_in, duv_data_in};

    generate
        for (genvar s = 0; s < 2; s++) begin : g_side
            // A cycle with both enables set is recorded as a write.
            assign push[s]     = en & syn[s] & (ren[s] | wen[s]);
            assign rec[s]      = {wen[s], addr[s], wen[s] ? dout[s] : din[s]};
            assign nonempty[s] = (level[s] != '0);

            cpu_lockstep_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr),
                .push_i  (push[s]),
                .rec_i   (rec[s]),
                .pop_i   (pop),
                .head_o  (head[s]),
                .level_o (level[s]),
                .drop_o  (drop[s])
            );
        end
    endgenerate

    assign pop = &nonempty;

    logic              cmp_vld_q, cmp_vld_d;
    logic [REC_W-1:0]  cmp_duv_q, cmp_duv_d, cmp_ref_q, cmp_ref_d;
    logic              mismatch_q, mismatch_d, err_q, err_d;
    logic              overflow_q, overflow_d, timeout_q, timeout_d;
    logic [REC_W-1:0]  first_duv_q, first_duv_d, first_ref_q, first_ref_d;
    logic [31:0]       cmp_cnt_q, cmp_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [SW-1:0]     skew_q, skew_d;

    assign differ = cmp_vld_q & (cmp_duv_q != cmp_ref_q);

    always_comb begin
        cmp_vld_d   = pop;
        cmp_duv_d   = pop ? head[DUV]  : cmp_duv_q;
        cmp_ref_d   = pop ? head[REFS] : cmp_ref_q;
        mismatch_d  = differ;
        err_d       = err_q | differ;
        cmp_cnt_d   = cmp_cnt_q + {31'd0, cmp_vld_q};
        err_cnt_d   = (differ && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        first_duv_d = (differ && !err_q) ? cmp_duv_q : first_duv_q;
        first_ref_d = (differ && !err_q) ? cmp_ref_q : first_ref_q;
        overflow_d  = overflow_q | (|drop);
        // Skew only accumulates while one side holds entries the other cannot match.
        if (^nonempty) skew_d = (skew_q == SKEW_MAX) ? skew_q : skew_q + 1'b1;
        else           skew_d = '0;
        timeout_d   = timeout_q | (skew_d == SKEW_MAX);
        if (clr) begin
            cmp_vld_d   = 1'b0;
            cmp_duv_d   = '0;
            cmp_ref_d   = '0;
            mismatch_d  = 1'b0;
            err_d       = 1'b0;
            cmp_cnt_d   = '0;
            err_cnt_d   = '0;
            first_duv_d = '0;
            first_ref_d = '0;
            overflow_d  = 1'b0;
            skew_d      = '0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_vld_q   <= 1'b0;
            cmp_duv_q   <= '0;
            cmp_ref_q   <= '0;
            mismatch_q  <= 1'b0;
            err_q       <= 1'b0;
            cmp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_duv_q <= '0;
            first_ref_q <= '0;
            overflow_q  <= 1'b0;
            skew_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            cmp_vld_q   <= cmp_vld_d;
            cmp_duv_q   <= cmp_duv_d;
            cmp_ref_q   <= cmp_ref_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            cmp_cnt_q   <= cmp_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_duv_q <= first_duv_d;
            first_ref_q <= first_ref_d;
            overflow_q  <= overflow_d;
            skew_q      <= skew_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mismatch      = mismatch_q;
    assign err           = err_q;
    assign overflow      = overflow_q;
    assign timeout       = timeout_q;
    assign first_duv_rec = first_duv_q;
    assign first_ref_rec = first_ref_q;
    assign cmp_count     = cmp_cnt_q;
    assign err_count     = err_cnt_q;
    assign duv_level     = level[DUV];
    assign ref_level     = level[REFS];
endmodule

// File: tb/tb_cpu_lockstep_cmp.sv
// Scoreboard bench for cpu_lockstep_cmp: queue-based reference model feeds expected
// compare pairs to a monitor that checks every result the DUT reports.

module tb_cpu_lockstep_cmp;
    localparam int AW = 16, DW = 8, DEPTH = 8, SKL = 4;
    localparam int RW = 1 + AW + DW, LW = $clog2(DEPTH) + 1;

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, clr = 1'b0;
    logic duv_syn_clk = 1'b0, duv_ren = 1'b0, duv_wen = 1'b0;
    logic ref_syn_clk = 1'b0, ref_ren = 1'b0, ref_wen = 1'b0;
    logic [AW-1:0] duv_addr_out = '0, ref_addr_out = '0;
    logic [DW-1:0] duv_data_out = '0, duv_data_in = '0, ref_data_out = '0, ref_data_in = '0;
    logic mismatch, err, overflow, timeout;
    logic [RW-1:0] first_duv_rec, first_ref_rec;
    logic [31:0] cmp_count;
    logic [15:0] err_count;
    logic [LW-1:0] duv_level, ref_level;

    always #5 clk = ~clk;

    cpu_lockstep_cmp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SKEW_LIMIT(SKL)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .duv_syn_clk(duv_syn_clk), .duv_addr_out(duv_addr_out), .duv_data_out(duv_data_out),
        .duv_data_in(duv_data_in), .duv_ren(duv_ren), .duv_wen(duv_wen),
        .ref_syn_clk(ref_syn_clk), .ref_addr_out(ref_addr_out), .ref_data_out(ref_data_out),
        .ref_data_in(ref_data_in), .ref_ren(ref_ren), .ref_wen(ref_wen),
        .mismatch(mismatch), .err(err), .overflow(overflow), .timeout(timeout),
        .first_duv_rec(first_duv_rec), .first_ref_rec(first_ref_rec),
        .cmp_count(cmp_count), .err_count(err_count),
        .duv_level(duv_level), .ref_level(ref_level)
    );

    typedef logic [RW-1:0] rec_t;
    typedef struct packed { rec_t d; rec_t r; } pair_t;

    rec_t  dq[$], rq[$];
    pair_t exp_q[$];
    int    sk = 0, m_cmp = 0, cyc = 0, last_mm = -1, mm_n = 0, ref_cyc = 0;
    bit    m_ovf = 0, m_to = 0, mon_sync = 1;
    int    n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic rec_t mk(input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] dout, input logic [DW-1:0] din);
        return {w, a, (w ? dout : din)};
    endfunction

    task automatic model_clear();
        dq.delete(); rq.delete(); exp_q.delete();
        sk = 0; m_ovf = 0; m_to = 0; m_cmp = 0; mon_sync = 1;
    endtask

    // Model of one clock edge, evaluated against pre-edge occupancy.
    task automatic model_edge();
        bit pop;
        if (!rst || clr) begin model_clear(); return; end
        if ((dq.size() != 0) != (rq.size() != 0)) begin
            if (sk < SKL) sk++;
        end else sk = 0;
        if (sk == SKL) m_to = 1;
        pop = (dq.size() != 0) && (rq.size() != 0);
        if (pop) begin
            pair_t p;
            p.d = dq.pop_front();
            p.r = rq.pop_front();
            exp_q.push_back(p);
            m_cmp++;
        end
        if (en && duv_syn_clk && (duv_ren || duv_wen)) begin
            if (dq.size() < DEPTH) dq.push_back(mk(duv_wen, duv_addr_out, duv_data_out, duv_data_in));
            else m_ovf = 1;
        end
        if (en && ref_syn_clk && (ref_ren || ref_wen)) begin
            if (rq.size() < DEPTH) rq.push_back(mk(ref_wen, ref_addr_out, ref_data_out, ref_data_in));
            else m_ovf = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("duv_level", 64'(duv_level), 64'(dq.size()));
        chk("ref_level", 64'(ref_level), 64'(rq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("timeout", 64'(timeout), 64'(m_to));
        duv_syn_clk = 1'b0; ref_syn_clk = 1'b0; clr = 1'b0;
    endtask

    task automatic set_duv(input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] dout, input logic [DW-1:0] din);
        duv_syn_clk = 1'b1; duv_ren = r; duv_wen = w;
        duv_addr_out = a; duv_data_out = dout; duv_data_in = din;
    endtask

    task automatic set_ref(input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] dout, input logic [DW-1:0] din);
        ref_syn_clk = 1'b1; ref_ren = r; ref_wen = w;
        ref_addr_out = a; ref_data_out = dout; ref_data_in = din;
    endtask

    task automatic drain(input string nm);
        repeat (DEPTH + 4) tick();
        chk({nm, "_cmp_count"}, 64'(cmp_count), 64'(m_cmp));
        chk({nm, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_flags"}, 64'({mismatch, err, overflow, timeout, duv_level, ref_level}), 64'd0);
        chk({nm, "_counts"}, 64'({cmp_count, err_count}), 64'd0);
        chk({nm, "_first"}, 64'({first_duv_rec, first_ref_rec}), 64'd0);
    endtask

    // Monitor: consumes one expected pair per cmp_count step.
    logic [31:0] prev_cnt = '0;
    int   m_errcnt = 0;
    rec_t m_fd = '0, m_fr = '0;
    always @(negedge clk) begin
        if (!rst || mon_sync) begin
            prev_cnt = cmp_count;
            m_errcnt = 0; m_fd = '0; m_fr = '0;
            chk("mon_sync_mismatch", 64'(mismatch), 64'd0);
            mon_sync = 0;
        end else if (cmp_count == prev_cnt + 32'd1) begin
            if (exp_q.size() == 0) chk("mon_unexpected_compare", 64'(cmp_count), 64'(prev_cnt));
            else begin
                pair_t p;
                bit dif;
                p = exp_q.pop_front();
                dif = (p.d != p.r);
                if (dif) begin
                    if (m_errcnt == 0) begin m_fd = p.d; m_fr = p.r; end
                    if (m_errcnt < 16'hFFFF) m_errcnt++;
                end
                chk("mon_mismatch", 64'(mismatch), 64'(dif));
                chk("mon_err_count", 64'(err_count), 64'(m_errcnt));
                chk("mon_err", 64'(err), 64'(m_errcnt != 0));
                chk("mon_first_duv", 64'(first_duv_rec), 64'(m_fd));
                chk("mon_first_ref", 64'(first_ref_rec), 64'(m_fr));
            end
            if (mismatch) begin last_mm = cyc; mm_n++; end
            prev_cnt = cmp_count;
        end else begin
            chk("mon_cmp_count_step", 64'(cmp_count), 64'(prev_cnt));
            chk("mon_idle_mismatch", 64'(mismatch), 64'd0);
            prev_cnt = cmp_count;
        end
    end

    task automatic rand_side(input int s);
        logic r, w;
        logic [AW-1:0] a;
        logic [DW-1:0] o, i;
        r = 1'($urandom); w = 1'($urandom);
        a = AW'($urandom_range(0, 3)); o = DW'($urandom_range(0, 3)); i = DW'($urandom_range(0, 3));
        if (s == 0) set_duv(r, w, a, o, i); else set_ref(r, w, a, o, i);
    endtask

    initial begin
        #2 rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Matched write stream
        mm_n = 0;
        for (int i = 0; i < 16; i++) begin
            set_duv(1'b0, 1'b1, AW'(16'h1000 + i), DW'(i), 8'h00);
            set_ref(1'b0, 1'b1, AW'(16'h1000 + i), DW'(i), 8'h00);
            tick();
        end
        drain("matched");
        chk("matched_cmp16", 64'(cmp_count), 64'd16);
        chk("matched_err", 64'(err), 64'd0);
        chk("matched_no_pulse", 64'(mm_n), 64'd0);

        // Skewed reads with one differing return value
        clr = 1'b1; tick();
        mm_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) set_duv(1'b1, 1'b0, AW'(16'h2000 + i), 8'h00, (i == 2) ? 8'h55 : DW'(i));
            else       set_ref(1'b1, 1'b0, AW'(16'h2000 + i - 5), 8'h00, (i == 7) ? 8'hAA : DW'(i - 5));
            tick();
            if (i == 7) ref_cyc = cyc;
        end
        drain("skew");
        chk("skew_one_pulse", 64'(mm_n), 64'd1);
        chk("skew_pulse_cycle", 64'(last_mm), 64'(ref_cyc + 2));
        chk("skew_first_duv", 64'(first_duv_rec), 64'({1'b0, 16'h2002, 8'h55}));
        chk("skew_first_ref", 64'(first_ref_rec), 64'({1'b0, 16'h2002, 8'hAA}));
        chk("skew_err_count", 64'(err_count), 64'd1);

        // Overflow: nine DUV pushes into an eight-deep FIFO
        clr = 1'b1; tick();
        for (int i = 0; i < 9; i++) begin
            set_duv(1'b0, 1'b1, AW'(16'h3000 + i), DW'(i), 8'h00);
            tick();
        end
        chk("ovf_level", 64'(duv_level), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            set_ref(1'b0, 1'b1, AW'(16'h3000 + i), DW'(i), 8'h00);
            tick();
        end
        drain("ovf");
        chk("ovf_cmp8", 64'(cmp_count), 64'd8);
        chk("ovf_err", 64'(err), 64'd0);

        // Timeout: one DUV record, reference silent
        clr = 1'b1; tick();
        set_duv(1'b1, 1'b1, 16'h4000, 8'h12, 8'h34);
        tick();
        repeat (3) tick();
        chk("to_before_limit", 64'(timeout), 64'd0);
        tick();
        chk("to_at_limit", 64'(timeout), 64'd1);
        set_ref(1'b0, 1'b1, 16'h4000, 8'h12, 8'h99);
        tick();
        drain("to");
        chk("to_cmp1", 64'(cmp_count), 64'd1);

        // clr colliding with a push and an in-flight differing compare
        clr = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            set_duv(1'b0, 1'b1, 16'h5000, 8'h01, 8'h00);
            set_ref(1'b0, 1'b1, 16'h5000, 8'h02, 8'h00);
            tick();
        end
        set_duv(1'b0, 1'b1, 16'h5001, 8'h01, 8'h00);
        set_ref(1'b0, 1'b1, 16'h5001, 8'h03, 8'h00);
        clr = 1'b1;
        tick();
        chk_all_zero("clr_coll");
        mm_n = 0;
        repeat (3) tick();
        chk("clr_no_pulse", 64'(mm_n), 64'd0);

        // Randomized traffic with occasional clr, en gaps and a mid-traffic reset
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) != 0) rand_side(0);
            if ($urandom_range(0, 2) != 0) rand_side(1);
            clr = ($urandom_range(0, 60) == 0);
            if (i == 250) begin
                #2 rst = 1'b0;
                #1 chk_all_zero("mid_reset");
                model_clear();
                tick();
                rst = 1'b1;
            end else tick();
        end
        en = 1'b1;
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/cpu_lockstep_cmp.md
# cpu_lockstep_cmp

Lockstep bus-transaction comparator for the 6502 verification environment. It sits between the DUV CPU and the reference-model CPU bus outputs and captures every qualified bus cycle from each side into a per-side FIFO. This lets the two cores run with bounded cycle skew. Entries are compared in order, and the block reports mismatches, counts, overflow and skew timeout. It generalises the single shared CPU interface to parametrised address/data width, skew-buffer depth and skew limit.

## Interface
Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- DEPTH, 8, entries per side FIFO; power of two, ≥2
- SKEW_LIMIT, 64, cycles one side may hold entries while the other is empty before timeout; ≥1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  capture enable; 0 blocks pushes, compare continues
- clr  in  1  synchronous clear: flush FIFOs, zero counters, clear sticky flags and capture regs
- duv_syn_clk  in  1  DUV bus-cycle strobe (one clk wide)
- duv_addr_out  in  ADDR_W  DUV address
- duv_data_out  in  DATA_W  DUV write data
- duv_data_in  in  DATA_W  data returned to DUV
- duv_ren, duv_wen  in  1  DUV read/write enables
- ref_syn_clk, ref_addr_out, ref_data_out, ref_data_in, ref_ren, ref_wen: same as the DUV ports, for the reference core
- mismatch  out  1  one-cycle pulse per differing pair
- err  out  1  sticky: any mismatch since reset/clr
- overflow  out  1  sticky: a record was dropped
- timeout  out  1  sticky: skew limit reached
- first_duv_rec, first_ref_rec  out  1+ADDR_W+DATA_W  records of first mismatch
- cmp_count  out  32  pairs compared, wraps
- err_count  out  16  mismatching pairs, saturates at 0xFFFF
- duv_level, ref_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Record = {wen, addr, data}; data = data_out when wen, else data_in. Read and write both set: treated as write.
- Push side X when en & X_syn_clk & (X_ren | X_wen).
- Pop both when both FIFOs non-empty, once per cycle.
- Compare happens in the stage after pop, registered. If records differ: mismatch=1, err_count += 1 (saturating). If err was 0, first_* are loaded and err is set.
- cmp_count increments for every compared pair.
- Push when full: accepted only if the same side pops that cycle. Otherwise the record is dropped, overflow is set and the level is unchanged.
- Skew counter:
  - Increments while exactly one FIFO is non-empty.
  - Resets to 0 otherwise.
  - When it reaches SKEW_LIMIT, timeout is set and the counter holds.
  - Compare continues after timeout.
- en=0 blocks new captures only. Buffered entries still drain and compare.
- clr has priority over push, pop and compare in that cycle. The in-flight compare stage is discarded (no mismatch pulse).
- FIFO pointers wrap modulo DEPTH. The level distinguishes full from empty.

## Timing
- Reset (rst=0, async) state:
  - All outputs 0: mismatch, err, overflow, timeout, counters, first_* and levels.
  - FIFOs are empty and the skew counter is 0.
- Deassertion is synchronous to clk.
- Push at edge t makes the entry visible at t (level updates after t).
- Pop happens at edge t+1 if the other side is non-empty.
- mismatch and counter updates are visible after edge t+2.
- Both sides strobing in the same cycle gives 2-cycle latency from strobe edge to result.
- Side B lagging k cycles: result appears 2 cycles after B's strobe.
- Throughput: one compare per cycle.
- Reset asserted mid-operation clears everything immediately and drops the in-flight compare.

## Test plan
- Reset: drive rst=0 mid-traffic -> all outputs 0 immediately, levels 0.
- Matched stream: both sides strobe writes A=0x1000..0x100F, D=i at the same cycle -> cmp_count=16, err=0, mismatch never pulses.
- Skew + mismatch: ref lags 5 cycles, and the 3rd DUV read returns 0x55 vs ref 0xAA -> single mismatch pulse 2 cycles after the ref strobe, first_duv_rec={0,addr,0x55}, first_ref_rec={0,addr,0xAA}, err_count=1.
- Overflow: DEPTH=8, DUV pushes 9 records while ref is idle -> duv_level=8, overflow=1. After ref supplies 8 matching records, cmp_count=8 and err=0.
- Timeout: SKEW_LIMIT=4, DUV pushes 1 record with ref silent -> timeout=1 after 4 cycles. A ref push then gives cmp_count=1.
- clr collision: clr asserted in the same cycle as a push and a pending compare -> levels 0, counters 0, no mismatch pulse, sticky flags cleared.
